// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the shared bitwise logic unit and its arbiter.
// Opcode encoding is visible to both requesters and to the combinational core.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        LOP_AND = 2'b00,
        LOP_OR  = 2'b01,
        LOP_XOR = 2'b10,
        LOP_BIC = 2'b11
    } lop_t;

    localparam int LU_WIDTH = 64;

endpackage

// File: rtl/logic_core.sv
// Purely combinational bitwise unit: AND / OR / XOR / AND-NOT selected by opcode.
// No carries cross bit positions, so the result is exactly WIDTH bits.
module logic_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH
) (
    input  lop_t             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_bic;

    assign w_and = i_a & i_b;
    assign w_or  = i_a | i_b;
    assign w_xor = i_a ^ i_b;
    assign w_bic = i_a & ~i_b;

    always_comb begin
        o_y = w_and;
        case (i_op)
            LOP_AND: o_y = w_and;
            LOP_OR:  o_y = w_or;
            LOP_XOR: o_y = w_xor;
            LOP_BIC: o_y = w_bic;
            default: o_y = w_and;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one logic_core between two requesters, with a two-stage
// pipeline (operand register, result register) and a backpressured response port.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_src,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_zero
);

    logic             r_last_gnt;

    logic             r_vld_p1;
    lop_t             r_op_p1;
    logic [WIDTH-1:0] r_a_p1;
    logic [WIDTH-1:0] r_b_p1;
    logic [TAG_W-1:0] r_tag_p1;
    logic             r_src_p1;

    logic             r_vld_p2;
    logic [WIDTH-1:0] r_data_p2;
    logic             r_src_p2;
    logic [TAG_W-1:0] r_tag_p2;
    logic             r_zero_p2;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_gnt_vld;
    logic             w_gnt;
    logic             w_hs0;
    logic             w_hs1;
    logic             w_hs;
    logic [WIDTH-1:0] w_core_y;

    assign w_adv2 = !r_vld_p2 | resp_ready;
    assign w_adv1 = !r_vld_p1 | w_adv2;

    // Contested cycles go to the requester opposite the last completed handshake.
    assign w_gnt_vld = req0_valid | req1_valid;
    assign w_gnt     = (req0_valid & req1_valid) ? ~r_last_gnt : req1_valid;

    // Gated by reset_n so neither requester sees ready while the block is held in reset.
    assign req0_ready = reset_n & w_adv1 & w_gnt_vld & ~w_gnt;
    assign req1_ready = reset_n & w_adv1 & w_gnt_vld &  w_gnt;

    assign w_hs0 = req0_valid & req0_ready;
    assign w_hs1 = req1_valid & req1_ready;
    assign w_hs  = w_hs0 | w_hs1;

    logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op (r_op_p1),
        .i_a  (r_a_p1),
        .i_b  (r_b_p1),
        .o_y  (w_core_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_gnt <= 1'b1;
            r_vld_p1   <= 1'b0;
            r_op_p1    <= LOP_AND;
            r_a_p1     <= '0;
            r_b_p1     <= '0;
            r_tag_p1   <= '0;
            r_src_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_data_p2  <= '0;
            r_src_p2   <= 1'b0;
            r_tag_p2   <= '0;
            r_zero_p2  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_last_gnt <= w_gnt;
            end

            // Stage 1: operand register, loaded with the granted request
            if (w_adv1) begin
                r_vld_p1 <= w_hs;
                r_src_p1 <= w_gnt;
                r_op_p1  <= lop_t'(w_gnt ? req1_op  : req0_op);
                r_a_p1   <= w_gnt ? req1_a   : req0_a;
                r_b_p1   <= w_gnt ? req1_b   : req0_b;
                r_tag_p1 <= w_gnt ? req1_tag : req0_tag;
            end

            // Stage 2: result register; zero flag captured alongside the data
            if (w_adv2) begin
                r_vld_p2  <= r_vld_p1;
                r_data_p2 <= w_core_y;
                r_zero_p2 <= (w_core_y == '0);
                r_src_p2  <= r_src_p1;
                r_tag_p2  <= r_tag_p1;
            end
        end
    end

    assign resp_valid = r_vld_p2;
    assign resp_data  = r_data_p2;
    assign resp_src   = r_src_p2;
    assign resp_tag   = r_tag_p2;
    assign resp_zero  = r_zero_p2;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, latency, round-robin, backpressure,
// opcodes, idle fairness and mid-flight reset, with hand-computed expectations.
module tb_logic_unit_arbiter;
    import logic_unit_pkg::*;

    localparam int W  = 64;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic [1:0]    req0_op = 2'b00;
    logic [W-1:0]  req0_a = '0;
    logic [W-1:0]  req0_b = '0;
    logic [TW-1:0] req0_tag = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic [1:0]    req1_op = 2'b00;
    logic [W-1:0]  req1_a = '0;
    logic [W-1:0]  req1_b = '0;
    logic [TW-1:0] req1_tag = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [W-1:0]  resp_data;
    logic          resp_src;
    logic [TW-1:0] resp_tag;
    logic          resp_zero;

    int total = 0;
    int bad   = 0;

    logic [1:0]   v_op  [4];
    logic [W-1:0] v_a   [4];
    logic [W-1:0] v_b   [4];
    logic [W-1:0] v_exp [4];
    logic         v_z   [4];

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .resp_tag   (resp_tag),
        .resp_zero  (resp_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", name, obs, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk_resp(input string name, input logic [W-1:0] d, input logic s,
                            input logic [TW-1:0] t, input logic z);
        chk1 ({name, "_valid"}, resp_valid, 1'b1);
        chk64({name, "_data"},  resp_data,  d);
        chk1 ({name, "_src"},   resp_src,   s);
        chk4 ({name, "_tag"},   resp_tag,   t);
        chk1 ({name, "_zero"},  resp_zero,  z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with req0 asserting valid during reset
        req0_valid = 1'b1;
        #12;
        chk1 ("rst_req0_ready", req0_ready, 1'b0);
        chk1 ("rst_resp_valid", resp_valid, 1'b0);
        chk64("rst_resp_data",  resp_data,  64'h0);
        chk1 ("rst_resp_src",   resp_src,   1'b0);
        chk4 ("rst_resp_tag",   resp_tag,   4'h0);
        chk1 ("rst_resp_zero",  resp_zero,  1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Contention: both valid, grants alternate starting with requester 0
        req0_op = LOP_OR; req0_b = '0; req0_tag = 4'd0; req0_a = 64'h1000; req0_valid = 1'b1;
        req1_op = LOP_OR; req1_b = '0; req1_tag = 4'd1; req1_a = 64'h1001; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                chk1($sformatf("cont_rdy0_%0d", i), req0_ready, (i % 2) == 0);
                chk1($sformatf("cont_rdy1_%0d", i), req1_ready, (i % 2) == 1);
            end
            if (i >= 2)
                chk_resp($sformatf("cont_resp_%0d", i - 2), 64'h1000 + 64'(i - 2),
                         ((i % 2) == 1), 4'(i - 2), 1'b0);
            tick();
            if (i < 6) begin
                if ((i % 2) == 0) begin
                    req0_tag = 4'(i + 2);
                    req0_a   = 64'h1000 + 64'(i + 2);
                    if (i + 2 >= 6) req0_valid = 1'b0;
                end else begin
                    req1_tag = 4'(i + 2);
                    req1_a   = 64'h1000 + 64'(i + 2);
                    if (i + 2 >= 6) req1_valid = 1'b0;
                end
            end
            #1;
        end
        chk1("cont_drained", resp_valid, 1'b0);

        // Single op latency: handshake, then result two edges later
        req0_op = LOP_AND; req0_a = 64'hFF00_FF00_FF00_FF00;
        req0_b = 64'h0F0F_0F0F_0F0F_0F0F; req0_tag = 4'd3; req0_valid = 1'b1;
        #1;
        chk1("single_rdy0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk1("single_lat1", resp_valid, 1'b0);
        tick();
        chk_resp("single", 64'h0F00_0F00_0F00_0F00, 1'b0, 4'd3, 1'b0);
        tick();
        chk1("single_gone", resp_valid, 1'b0);

        // Backpressure: two ops fill the pipeline, then ready drops
        resp_ready = 1'b0;
        req0_op = LOP_OR; req0_b = '0; req0_a = 64'h2000; req0_tag = 4'd0; req0_valid = 1'b1;
        #1;
        chk1("bp_rdy_a", req0_ready, 1'b1);
        tick();
        req0_a = 64'h2001; req0_tag = 4'd1;
        #1;
        chk1("bp_rdy_b", req0_ready, 1'b1);
        tick();
        req0_a = 64'h2002; req0_tag = 4'd2;
        #1;
        chk1("bp_rdy_full", req0_ready, 1'b0);
        chk_resp("bp_hold0", 64'h2000, 1'b0, 4'd0, 1'b0);
        tick();
        chk1("bp_rdy_full2", req0_ready, 1'b0);
        chk_resp("bp_hold1", 64'h2000, 1'b0, 4'd0, 1'b0);
        resp_ready = 1'b1;
        #1;
        chk1("bp_rdy_simul", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk_resp("bp_drain1", 64'h2001, 1'b0, 4'd1, 1'b0);
        tick();
        chk_resp("bp_drain2", 64'h2002, 1'b0, 4'd2, 1'b0);
        tick();
        chk1("bp_empty", resp_valid, 1'b0);

        // Opcodes, streamed back-to-back on requester 0
        v_op[0] = LOP_OR;  v_a[0] = 64'hAAAA_AAAA_AAAA_AAAA; v_b[0] = 64'hFFFF_FFFF_0000_0000;
        v_exp[0] = 64'hFFFF_FFFF_AAAA_AAAA; v_z[0] = 1'b0;
        v_op[1] = LOP_XOR; v_a[1] = 64'hAAAA_AAAA_AAAA_AAAA; v_b[1] = 64'hFFFF_FFFF_0000_0000;
        v_exp[1] = 64'h5555_5555_AAAA_AAAA; v_z[1] = 1'b0;
        v_op[2] = LOP_BIC; v_a[2] = 64'hAAAA_AAAA_AAAA_AAAA; v_b[2] = 64'hFFFF_FFFF_0000_0000;
        v_exp[2] = 64'h0000_0000_AAAA_AAAA; v_z[2] = 1'b0;
        v_op[3] = LOP_XOR; v_a[3] = 64'h1234_5678_9ABC_DEF0; v_b[3] = 64'h1234_5678_9ABC_DEF0;
        v_exp[3] = 64'h0; v_z[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req0_op = v_op[i]; req0_a = v_a[i]; req0_b = v_b[i];
                req0_tag = 4'(i + 8); req0_valid = 1'b1;
            end else begin
                req0_valid = 1'b0;
            end
            #1;
            if (i < 4) chk1($sformatf("op_rdy_%0d", i), req0_ready, 1'b1);
            if (i >= 2)
                chk_resp($sformatf("op_resp_%0d", i - 2), v_exp[i - 2], 1'b0,
                         4'(i + 6), v_z[i - 2]);
            tick();
        end

        // Idle fairness: req1 alone twice, then contested grant goes to requester 0
        req1_op = LOP_OR; req1_b = '0; req1_a = 64'h3000; req1_tag = 4'd1; req1_valid = 1'b1;
        #1;
        chk1("fair_r1_a", req1_ready, 1'b1);
        tick();
        req1_a = 64'h3001; req1_tag = 4'd2;
        #1;
        chk1("fair_r1_b", req1_ready, 1'b1);
        tick();
        req1_a = 64'h3002; req1_tag = 4'd3;
        req0_op = LOP_OR; req0_b = '0; req0_a = 64'h3100; req0_tag = 4'd5; req0_valid = 1'b1;
        #1;
        chk1("fair_rdy0", req0_ready, 1'b1);
        chk1("fair_rdy1", req1_ready, 1'b0);
        chk_resp("fair_resp0", 64'h3000, 1'b1, 4'd1, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk1("fair_r1_c", req1_ready, 1'b1);
        chk_resp("fair_resp1", 64'h3001, 1'b1, 4'd2, 1'b0);
        tick();
        req1_valid = 1'b0;
        chk_resp("fair_resp2", 64'h3100, 1'b0, 4'd5, 1'b0);
        tick();
        chk_resp("fair_resp3", 64'h3002, 1'b1, 4'd3, 1'b0);
        tick();
        chk1("fair_empty", resp_valid, 1'b0);

        // Mid-flight reset with two operations held in the pipeline
        resp_ready = 1'b0;
        req0_op = LOP_OR; req0_b = '0; req0_a = 64'h4000; req0_tag = 4'd7; req0_valid = 1'b1;
        tick();
        req0_a = 64'h4001; req0_tag = 4'd8;
        tick();
        chk_resp("mrst_pre", 64'h4000, 1'b0, 4'd7, 1'b0);
        req1_op = LOP_OR; req1_b = '0; req1_a = 64'h4100; req1_tag = 4'd9; req1_valid = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk1 ("mrst_valid", resp_valid, 1'b0);
        chk64("mrst_data",  resp_data,  64'h0);
        chk4 ("mrst_tag",   resp_tag,   4'h0);
        chk1 ("mrst_rdy0",  req0_ready, 1'b0);
        #4;
        reset_n = 1'b1;
        resp_ready = 1'b1;
        #1;
        chk1("mrst_gnt0", req0_ready, 1'b1);
        chk1("mrst_gnt1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        chk1("mrst_drop_a", resp_valid, 1'b0);
        tick();
        chk1("mrst_drop_b", resp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
